// File: rtl/machine_control_pkg.sv
// Shared definitions for the machine-mode trap and sequencing controller:
// FSM state encodings, PC-source select codes and mcause code values.
package machine_control_pkg;

  // Controller states; the encoding is held in a register in the top.
  typedef enum logic [1:0] {
    ST_RESET       = 2'd0,
    ST_OPERATING   = 2'd1,
    ST_TRAP_TAKEN  = 2'd2,
    ST_TRAP_RETURN = 2'd3
  } state_t;

  // PC-generation source select.
  localparam logic [1:0] PC_BOOT     = 2'b00;
  localparam logic [1:0] PC_EPC      = 2'b01;
  localparam logic [1:0] PC_TRAP_VEC = 2'b10;
  localparam logic [1:0] PC_NEXT     = 2'b11;

  // Synchronous exception codes (mcause[31] = 0).
  localparam logic [3:0] EXC_INSTR_MISALIGNED = 4'd0;
  localparam logic [3:0] EXC_ILLEGAL_INSTR    = 4'd2;
  localparam logic [3:0] EXC_BREAKPOINT       = 4'd3;
  localparam logic [3:0] EXC_LOAD_MISALIGNED  = 4'd4;
  localparam logic [3:0] EXC_STORE_MISALIGNED = 4'd6;
  localparam logic [3:0] EXC_ECALL_M          = 4'd11;

  // Interrupt codes (mcause[31] = 1).
  localparam logic [3:0] IRQ_SOFTWARE_M = 4'd3;
  localparam logic [3:0] IRQ_TIMER_M    = 4'd7;
  localparam logic [3:0] IRQ_EXTERNAL_M = 4'd11;

endpackage

// File: rtl/machine_control_trap_cause_enc.sv
// Combinational priority encoder: turns the raw exception flags and the
// already-enabled interrupt requests into an mcause code, the interrupt
// flag, the misaligned-access flag and a single "some trap" indication.
// Exceptions always outrank interrupts.
module trap_cause_enc
  import machine_control_pkg::*;
#(
  parameter int CAUSE_W = 4
) (
  input  logic               misaligned_instr,
  input  logic               illegal_instr,
  input  logic               ebreak,
  input  logic               ecall,
  input  logic               misaligned_load,
  input  logic               misaligned_store,
  input  logic               ext_irq,
  input  logic               sw_irq,
  input  logic               timer_irq,
  output logic [CAUSE_W-1:0] cause,
  output logic               i_or_e,
  output logic               misaligned,
  output logic               any_trap
);

  logic any_exc;
  logic any_irq;

  assign any_exc  = misaligned_instr | illegal_instr | ebreak | ecall |
                    misaligned_load | misaligned_store;
  assign any_irq  = ext_irq | sw_irq | timer_irq;
  assign any_trap = any_exc | any_irq;

  // Highest-priority pending source selects the cause code.
  always_comb begin
    cause      = '0;
    i_or_e     = 1'b0;
    misaligned = 1'b0;
    if (misaligned_instr) begin
      cause      = CAUSE_W'(EXC_INSTR_MISALIGNED);
      misaligned = 1'b1;
    end else if (illegal_instr) begin
      cause = CAUSE_W'(EXC_ILLEGAL_INSTR);
    end else if (ebreak) begin
      cause = CAUSE_W'(EXC_BREAKPOINT);
    end else if (ecall) begin
      cause = CAUSE_W'(EXC_ECALL_M);
    end else if (misaligned_load) begin
      cause      = CAUSE_W'(EXC_LOAD_MISALIGNED);
      misaligned = 1'b1;
    end else if (misaligned_store) begin
      cause      = CAUSE_W'(EXC_STORE_MISALIGNED);
      misaligned = 1'b1;
    end else if (ext_irq) begin
      cause  = CAUSE_W'(IRQ_EXTERNAL_M);
      i_or_e = 1'b1;
    end else if (sw_irq) begin
      cause  = CAUSE_W'(IRQ_SOFTWARE_M);
      i_or_e = 1'b1;
    end else if (timer_irq) begin
      cause  = CAUSE_W'(IRQ_TIMER_M);
      i_or_e = 1'b1;
    end
  end

endmodule

// File: rtl/machine_control.sv
// Trap and sequencing controller for the RV32I core. Decides, once per
// non-stalled OPERATING cycle, whether the instruction in decode traps,
// returns via MRET or retires, and drives PC select, flush and the CSR
// trap strobes for the one-cycle TRAP_TAKEN / TRAP_RETURN states.
// Build option: define MACHINE_CONTROL_IRQ_EN to enable the interrupt
// path; without it only exceptions and MRET redirect program flow.
module machine_control
  import machine_control_pkg::*;
#(
  parameter int RESET_CYCLES = 1,
  parameter int CAUSE_W      = 4
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               stall_in,
  input  logic               illegal_instr_in,
  input  logic               misaligned_instr_in,
  input  logic               misaligned_load_in,
  input  logic               misaligned_store_in,
  input  logic               ecall_in,
  input  logic               ebreak_in,
  input  logic               mret_in,
  input  logic               mie_in,
  input  logic               meie_in,
  input  logic               mtie_in,
  input  logic               msie_in,
  input  logic               meip_in,
  input  logic               mtip_in,
  input  logic               msip_in,
  output logic [1:0]         pc_src_out,
  output logic               flush_out,
  output logic               trap_taken_out,
  output logic               i_or_e_out,
  output logic [CAUSE_W-1:0] cause_out,
  output logic               set_cause_out,
  output logic               set_epc_out,
  output logic               mie_clear_out,
  output logic               mie_set_out,
  output logic               instret_inc_out,
  output logic               misaligned_exception_out
);

`ifdef MACHINE_CONTROL_IRQ_EN
  localparam logic IRQ_EN = 1'b1;
`else
  localparam logic IRQ_EN = 1'b0;
`endif

  state_t               state_reg;
  logic [3:0]           count_reg;
  logic [1:0]           pc_src_reg;
  logic                 flush_reg;
  logic                 trap_taken_reg;
  logic                 i_or_e_reg;
  logic [CAUSE_W-1:0]   cause_reg;
  logic                 set_cause_reg;
  logic                 set_epc_reg;
  logic                 mie_clear_reg;
  logic                 mie_set_reg;
  logic                 misaligned_reg;

  logic                 ext_irq;
  logic                 sw_irq;
  logic                 timer_irq;
  logic [CAUSE_W-1:0]   enc_cause;
  logic                 enc_i_or_e;
  logic                 enc_misaligned;
  logic                 enc_any_trap;

  // Interrupts only count when globally enabled and individually enabled;
  // with the interrupt path compiled out they are constant zero.
  assign ext_irq   = IRQ_EN & mie_in & meie_in & meip_in;
  assign sw_irq    = IRQ_EN & mie_in & msie_in & msip_in;
  assign timer_irq = IRQ_EN & mie_in & mtie_in & mtip_in;

  trap_cause_enc #(
    .CAUSE_W(CAUSE_W)
  ) u_cause_enc (
    .misaligned_instr(misaligned_instr_in),
    .illegal_instr   (illegal_instr_in),
    .ebreak          (ebreak_in),
    .ecall           (ecall_in),
    .misaligned_load (misaligned_load_in),
    .misaligned_store(misaligned_store_in),
    .ext_irq         (ext_irq),
    .sw_irq          (sw_irq),
    .timer_irq       (timer_irq),
    .cause           (enc_cause),
    .i_or_e          (enc_i_or_e),
    .misaligned      (enc_misaligned),
    .any_trap        (enc_any_trap)
  );

  // State sequencing with registered per-state outputs; strobes default low.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_reg      <= ST_RESET;
      count_reg      <= 4'(RESET_CYCLES - 1);
      pc_src_reg     <= PC_BOOT;
      flush_reg      <= 1'b1;
      trap_taken_reg <= 1'b0;
      i_or_e_reg     <= 1'b0;
      cause_reg      <= '0;
      set_cause_reg  <= 1'b0;
      set_epc_reg    <= 1'b0;
      mie_clear_reg  <= 1'b0;
      mie_set_reg    <= 1'b0;
      misaligned_reg <= 1'b0;
    end else begin
      trap_taken_reg <= 1'b0;
      set_cause_reg  <= 1'b0;
      set_epc_reg    <= 1'b0;
      mie_clear_reg  <= 1'b0;
      mie_set_reg    <= 1'b0;
      case (state_reg)
        ST_RESET: begin
          if (count_reg == 4'd0) begin
            state_reg  <= ST_OPERATING;
            pc_src_reg <= PC_NEXT;
            flush_reg  <= 1'b0;
          end else begin
            count_reg  <= count_reg - 4'd1;
            pc_src_reg <= PC_BOOT;
            flush_reg  <= 1'b1;
          end
        end
        ST_OPERATING: begin
          if (!stall_in && enc_any_trap) begin
            state_reg      <= ST_TRAP_TAKEN;
            pc_src_reg     <= PC_TRAP_VEC;
            flush_reg      <= 1'b1;
            trap_taken_reg <= 1'b1;
            set_cause_reg  <= 1'b1;
            set_epc_reg    <= 1'b1;
            mie_clear_reg  <= 1'b1;
            cause_reg      <= enc_cause;
            i_or_e_reg     <= enc_i_or_e;
            misaligned_reg <= enc_misaligned;
          end else if (!stall_in && mret_in) begin
            state_reg   <= ST_TRAP_RETURN;
            pc_src_reg  <= PC_EPC;
            flush_reg   <= 1'b1;
            mie_set_reg <= 1'b1;
          end else begin
            pc_src_reg <= PC_NEXT;
            flush_reg  <= 1'b0;
          end
        end
        default: begin
          // TRAP_TAKEN and TRAP_RETURN last one cycle; events seen here are dropped.
          state_reg  <= ST_OPERATING;
          pc_src_reg <= PC_NEXT;
          flush_reg  <= 1'b0;
        end
      endcase
    end
  end

  // The instruction in decode retires when it neither stalls, traps nor returns.
  assign instret_inc_out = (state_reg == ST_OPERATING) & ~stall_in &
                           ~enc_any_trap & ~mret_in;

  assign pc_src_out               = pc_src_reg;
  assign flush_out                = flush_reg;
  assign trap_taken_out           = trap_taken_reg;
  assign i_or_e_out               = i_or_e_reg;
  assign cause_out                = cause_reg;
  assign set_cause_out            = set_cause_reg;
  assign set_epc_out              = set_epc_reg;
  assign mie_clear_out            = mie_clear_reg;
  assign mie_set_out              = mie_set_reg;
  assign misaligned_exception_out = misaligned_reg;

endmodule

// File: tb/tb_machine_control.sv
// Self-checking bench for machine_control: a behavioural model predicts
// every output after each clock edge, plus directed literal checks.
module tb_machine_control;

  localparam int RESET_CYCLES = 2;
  localparam int CAUSE_W      = 4;
`ifdef MACHINE_CONTROL_IRQ_EN
  localparam bit IRQ_BUILD = 1'b1;
`else
  localparam bit IRQ_BUILD = 1'b0;
`endif

  // Exception priority order, highest first: flag index -> mcause code.
  localparam int EXC_CODE[6] = '{0, 2, 3, 11, 4, 6};
  // Interrupt priority order, highest first: ext, sw, timer.
  localparam int IRQ_CODE[3] = '{11, 3, 7};

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic rst_in, stall_in, illegal_instr_in, misaligned_instr_in;
  logic misaligned_load_in, misaligned_store_in, ecall_in, ebreak_in, mret_in;
  logic mie_in, meie_in, mtie_in, msie_in, meip_in, mtip_in, msip_in;
  logic [1:0]         pc_src_out;
  logic               flush_out, trap_taken_out, i_or_e_out;
  logic [CAUSE_W-1:0] cause_out;
  logic               set_cause_out, set_epc_out, mie_clear_out, mie_set_out;
  logic               instret_inc_out, misaligned_exception_out;

  machine_control #(
    .RESET_CYCLES(RESET_CYCLES),
    .CAUSE_W     (CAUSE_W)
  ) dut (
    .clk_in                  (clk_in),
    .rst_in                  (rst_in),
    .stall_in                (stall_in),
    .illegal_instr_in        (illegal_instr_in),
    .misaligned_instr_in     (misaligned_instr_in),
    .misaligned_load_in      (misaligned_load_in),
    .misaligned_store_in     (misaligned_store_in),
    .ecall_in                (ecall_in),
    .ebreak_in               (ebreak_in),
    .mret_in                 (mret_in),
    .mie_in                  (mie_in),
    .meie_in                 (meie_in),
    .mtie_in                 (mtie_in),
    .msie_in                 (msie_in),
    .meip_in                 (meip_in),
    .mtip_in                 (mtip_in),
    .msip_in                 (msip_in),
    .pc_src_out              (pc_src_out),
    .flush_out               (flush_out),
    .trap_taken_out          (trap_taken_out),
    .i_or_e_out              (i_or_e_out),
    .cause_out               (cause_out),
    .set_cause_out           (set_cause_out),
    .set_epc_out             (set_epc_out),
    .mie_clear_out           (mie_clear_out),
    .mie_set_out             (mie_set_out),
    .instret_inc_out         (instret_inc_out),
    .misaligned_exception_out(misaligned_exception_out)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // ---------------- behavioural model ----------------
  bit         valid = 1'b0;
  int         since_rst = 0;       // edges since reset was released
  bit         redirect_prev = 1'b0;
  bit         m_op = 1'b0;         // controller is making decisions this cycle
  logic [1:0] m_pc = 2'b00;
  bit         m_flush, m_trap, m_ioe, m_setc, m_sete, m_mclr, m_mset, m_mis;
  logic [3:0] m_cause = 4'd0;

  function automatic int exc_index();
    bit f[6];
    int idx = -1;
    f = '{misaligned_instr_in, illegal_instr_in, ebreak_in, ecall_in,
          misaligned_load_in, misaligned_store_in};
    for (int i = 5; i >= 0; i--) if (f[i]) idx = i;
    return idx;
  endfunction

  function automatic int irq_index();
    bit f[3];
    int idx = -1;
    f = '{meie_in & meip_in, msie_in & msip_in, mtie_in & mtip_in};
    if (IRQ_BUILD && mie_in)
      for (int i = 2; i >= 0; i--) if (f[i]) idx = i;
    return idx;
  endfunction

  always @(posedge clk_in) begin
    int e, q, code;
    if (rst_in) begin
      valid = 1'b1; since_rst = 0; redirect_prev = 1'b0; m_op = 1'b0;
      m_pc = 2'b00; m_flush = 1'b1; m_trap = 1'b0; m_ioe = 1'b0;
      m_setc = 1'b0; m_sete = 1'b0; m_mclr = 1'b0; m_mset = 1'b0;
      m_mis = 1'b0; m_cause = 4'd0;
    end else if (valid) begin
      m_trap = 1'b0; m_setc = 1'b0; m_sete = 1'b0; m_mclr = 1'b0; m_mset = 1'b0;
      if (since_rst <= RESET_CYCLES) since_rst = since_rst + 1;
      e = exc_index();
      q = irq_index();
      if (since_rst < RESET_CYCLES) begin
        m_pc = 2'b00; m_flush = 1'b1; m_op = 1'b0;
      end else if (since_rst == RESET_CYCLES || redirect_prev || stall_in ||
                   (e < 0 && q < 0 && !mret_in)) begin
        m_pc = 2'b11; m_flush = 1'b0; m_op = 1'b1; redirect_prev = 1'b0;
      end else if (e >= 0 || q >= 0) begin
        code    = (e >= 0) ? EXC_CODE[e] : IRQ_CODE[q];
        m_cause = 4'(code);
        m_ioe   = (e < 0);
        m_mis   = (e >= 0) && (code == 0 || code == 4 || code == 6);
        m_pc = 2'b10; m_flush = 1'b1; m_trap = 1'b1;
        m_setc = 1'b1; m_sete = 1'b1; m_mclr = 1'b1;
        m_op = 1'b0; redirect_prev = 1'b1;
      end else begin
        m_pc = 2'b01; m_flush = 1'b1; m_mset = 1'b1;
        m_op = 1'b0; redirect_prev = 1'b1;
      end
    end
  end

  // One clock edge, then compare every output against the model mid-cycle.
  task automatic step();
    logic [14:0] got, want;
    bit m_inc;
    @(posedge clk_in);
    @(negedge clk_in);
    cyc++;
    if (valid) begin
      m_inc = m_op && !stall_in && exc_index() < 0 && irq_index() < 0 && !mret_in;
      got  = {pc_src_out, flush_out, trap_taken_out, i_or_e_out, cause_out,
              set_cause_out, set_epc_out, mie_clear_out, mie_set_out,
              instret_inc_out, misaligned_exception_out};
      want = {m_pc, m_flush, m_trap, m_ioe, m_cause, m_setc, m_sete, m_mclr,
              m_mset, m_inc, m_mis};
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL model_cmp cyc=%0d got=%h want=%h", cyc, got, want);
      end
    end
  endtask

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, got, want);
    end
  endtask

  task automatic clear_events();
    illegal_instr_in = 0; misaligned_instr_in = 0; misaligned_load_in = 0;
    misaligned_store_in = 0; ecall_in = 0; ebreak_in = 0; mret_in = 0;
    mie_in = 0; meie_in = 0; mtie_in = 0; msie_in = 0;
    meip_in = 0; mtip_in = 0; msip_in = 0; stall_in = 0;
  endtask

  // {mret, mis_instr, illegal, ebreak, ecall, mis_load, mis_store}
  localparam logic [6:0] VEC_FLAGS[7] = '{7'b0100100, 7'b0001100, 7'b0000100,
                                          7'b0000011, 7'b0000001, 7'b0011001,
                                          7'b1010000};
  localparam int VEC_CAUSE[7] = '{0, 3, 11, 4, 6, 2, 2};
  localparam int VEC_MIS[7]   = '{1, 0, 0, 1, 1, 0, 0};

  initial begin
    logic [6:0] f;
    clear_events();
    rst_in = 1;

    // Reset held three cycles, then RESET_CYCLES boot cycles.
    step(); step(); step();
    check("rst_pc", int'(pc_src_out), 0);
    check("rst_flush", int'(flush_out), 1);
    check("rst_cause", int'(cause_out), 0);
    rst_in = 0;
    step();
    check("boot_pc", int'(pc_src_out), 0);
    check("boot_flush", int'(flush_out), 1);
    step();
    check("run_pc", int'(pc_src_out), 3);
    check("run_instret", int'(instret_inc_out), 1);
    $display("reset/boot sequence done cyc=%0d", cyc);

    // Illegal + misaligned load: illegal wins.
    illegal_instr_in = 1; misaligned_load_in = 1;
    step();
    check("ill_trap", int'(trap_taken_out), 1);
    check("ill_cause", int'(cause_out), 2);
    check("ill_ioe", int'(i_or_e_out), 0);
    check("ill_epc", int'(set_epc_out), 1);
    check("ill_pc", int'(pc_src_out), 2);
    clear_events();
    step();
    check("ill_after_pc", int'(pc_src_out), 3);
    check("ill_after_trap", int'(trap_taken_out), 0);
    $display("illegal+misaligned_load trap done cyc=%0d", cyc);

    // Timer + software interrupt: software wins (irq build only).
    mie_in = 1; mtie_in = 1; mtip_in = 1; msie_in = 1; msip_in = 1;
    step();
    check("irq_trap", int'(trap_taken_out), int'(IRQ_BUILD));
    check("irq_cause", int'(cause_out), IRQ_BUILD ? 3 : 2);
    check("irq_ioe", int'(i_or_e_out), int'(IRQ_BUILD));
    check("irq_mclr", int'(mie_clear_out), int'(IRQ_BUILD));
    mie_in = 0;   // CSR file has cleared MIE; lines stay pending
    step();
    check("irq_masked_mclr", int'(mie_clear_out), 0);
    step();
    check("irq_masked_instret", int'(instret_inc_out), 1);
    clear_events();
    step();
    $display("software/timer interrupt done cyc=%0d", cyc);

    // MRET while stalled, then released.
    mret_in = 1; stall_in = 1;
    step();
    check("mret_stall_pc", int'(pc_src_out), 3);
    check("mret_stall_instret", int'(instret_inc_out), 0);
    step();
    check("mret_stall2_mset", int'(mie_set_out), 0);
    stall_in = 0;
    step();
    check("mret_pc", int'(pc_src_out), 1);
    check("mret_mset", int'(mie_set_out), 1);
    check("mret_instret", int'(instret_inc_out), 0);
    clear_events();
    step();
    check("mret_after_pc", int'(pc_src_out), 3);
    $display("stalled mret done cyc=%0d", cyc);

    // Exception priority vectors.
    for (int i = 0; i < 7; i++) begin
      f = VEC_FLAGS[i];
      {mret_in, misaligned_instr_in, illegal_instr_in, ebreak_in, ecall_in,
       misaligned_load_in, misaligned_store_in} = f;
      step();
      check("vec_trap", int'(trap_taken_out), 1);
      check("vec_cause", int'(cause_out), VEC_CAUSE[i]);
      check("vec_mis", int'(misaligned_exception_out), VEC_MIS[i]);
      clear_events();
      step();
      $display("exception vector %0d flags=%b done cyc=%0d", i, f, cyc);
    end

    // Illegal held: flushed in TRAP_TAKEN, then traps again.
    illegal_instr_in = 1;
    step(); step(); step();
    check("held_retrap", int'(trap_taken_out), 1);
    clear_events();
    step();
    $display("held illegal retrap done cyc=%0d", cyc);

    // Reset during TRAP_TAKEN.
    misaligned_store_in = 1;
    step();
    check("st_cause", int'(cause_out), 6);
    check("st_mis", int'(misaligned_exception_out), 1);
    clear_events();
    rst_in = 1;
    step();
    check("midrst_pc", int'(pc_src_out), 0);
    check("midrst_cause", int'(cause_out), 0);
    check("midrst_mis", int'(misaligned_exception_out), 0);
    check("midrst_trap", int'(trap_taken_out), 0);
    rst_in = 0;
    step(); step(); step();
    $display("reset during trap done cyc=%0d", cyc);

    // External interrupt: traps only in the irq build.
    mie_in = 1; meie_in = 1; meip_in = 1;
    step();
    check("ext_trap", int'(trap_taken_out), int'(IRQ_BUILD));
    check("ext_instret", int'(instret_inc_out), int'(!IRQ_BUILD));
    step(); step();
    clear_events();
    step(); step();
    $display("external interrupt done cyc=%0d", cyc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
